// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg: opcode constants, state encodings and legality check for the MIPS main control unit.
package control_fsm_pkg;
  localparam int OPCODE_WIDTH = 6;
  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'b001000;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  function automatic logic op_legal(input logic [OPCODE_WIDTH-1:0] op);
    return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI};
  endfunction
endpackage

// File: rtl/control_fsm_main_decoder.sv
// main_decoder: combinational opcode classification for the control unit.
module main_decoder
  import control_fsm_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] op,
  output logic                    is_r,
  output logic                    is_lw,
  output logic                    is_sw,
  output logic                    is_beq,
  output logic                    is_addi,
  output logic                    illegal
);
  assign is_r    = op == OP_RTYPE;
  assign is_lw   = op == OP_LW;
  assign is_sw   = op == OP_SW;
  assign is_beq  = op == OP_BEQ;
  assign is_addi = op == OP_ADDI;
  assign illegal = !op_legal(op);
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle MIPS main control, FETCH/DECODE/EXEC/MEM/WB sequencing with Moore control outputs.
module control_fsm
  import control_fsm_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                    cu_clk,
  input  logic                    cu_rst,
  input  logic                    cu_i_ce,
  input  logic [OPCODE_WIDTH-1:0] cu_i_opcode,
  output logic                    cu_o_ce,
  output logic                    cu_o_RegDst,
  output logic                    cu_o_RegWrite,
  output logic                    cu_o_Branch,
  output logic                    cu_o_ALUSrc,
  output logic                    cu_o_MemRead,
  output logic                    cu_o_MemWrite,
  output logic                    cu_o_MemtoReg,
  output logic                    cu_o_busy,
  output logic                    cu_o_illegal,
  output logic [CNT_WIDTH-1:0]    cu_o_instr_count
);
  logic [2:0] state, state_nxt, leave;
  logic [OPCODE_WIDTH-1:0] op;
  logic is_r, is_lw, is_sw, is_beq, is_addi, op_bad, in_instr, done, dec_legal;

  main_decoder u_dec (
    .op(op), .is_r(is_r), .is_lw(is_lw), .is_sw(is_sw),
    .is_beq(is_beq), .is_addi(is_addi), .illegal(op_bad)
  );

  // DECODE branches on the live opcode; everything later uses the latched copy
  assign dec_legal = op_legal(cu_i_opcode);
  assign leave     = cu_i_ce ? S_FETCH : S_IDLE;
  assign done      = !op_bad && (state == S_WB || (state == S_MEM && is_sw) || (state == S_EXEC && is_beq));

  always_comb begin
    state_nxt = state == S_IDLE   ? leave :
                state == S_FETCH  ? S_DECODE :
                state == S_DECODE ? (dec_legal ? S_EXEC : leave) :
                state == S_EXEC   ? ((is_r || is_addi) ? S_WB : (is_lw || is_sw) ? S_MEM : leave) :
                state == S_MEM    ? (is_lw ? S_WB : leave) :
                state == S_WB     ? leave : S_IDLE;
  end

  always_ff @(posedge cu_clk or negedge cu_rst) begin
    if (!cu_rst) begin
      state            <= S_IDLE;
      op               <= '0;
      cu_o_illegal     <= 1'b0;
      cu_o_instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) op <= cu_i_opcode;
      if (state == S_DECODE && !dec_legal) cu_o_illegal <= 1'b1;
      if (done) cu_o_instr_count <= cu_o_instr_count + 1'b1;
    end
  end

  assign in_instr      = state == S_EXEC || state == S_MEM || state == S_WB;
  assign cu_o_ce       = state == S_FETCH;
  assign cu_o_busy     = state != S_IDLE;
  assign cu_o_RegDst   = in_instr && is_r;
  assign cu_o_ALUSrc   = in_instr && (is_lw || is_sw || is_addi);
  assign cu_o_MemtoReg = in_instr && is_lw;
  assign cu_o_Branch   = state == S_EXEC && is_beq;
  assign cu_o_MemRead  = state == S_MEM && is_lw;
  assign cu_o_MemWrite = state == S_MEM && is_sw;
  assign cu_o_RegWrite = state == S_WB;
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench; driver queues per-cycle expected controls, monitor compares on the falling edge.
module tb_control_fsm;
  import control_fsm_pkg::*;
  logic clk = 0, rst_n = 0, ce = 0;
  logic [5:0] opcode = 6'h3f;
  logic o_ce, o_regdst, o_regwrite, o_branch, o_alusrc, o_memread, o_memwrite, o_memtoreg, o_busy, o_illegal;
  logic [3:0] o_cnt;
  logic [13:0] q[$];
  int total = 0, bad = 0;
  logic [3:0] cnt_exp = 0;
  logic ill_exp = 0;

  always #5 clk = ~clk;

  control_fsm #(.CNT_WIDTH(4)) dut (
    .cu_clk(clk), .cu_rst(rst_n), .cu_i_ce(ce), .cu_i_opcode(opcode),
    .cu_o_ce(o_ce), .cu_o_RegDst(o_regdst), .cu_o_RegWrite(o_regwrite),
    .cu_o_Branch(o_branch), .cu_o_ALUSrc(o_alusrc), .cu_o_MemRead(o_memread),
    .cu_o_MemWrite(o_memwrite), .cu_o_MemtoReg(o_memtoreg), .cu_o_busy(o_busy),
    .cu_o_illegal(o_illegal), .cu_o_instr_count(o_cnt)
  );

  // {ce,RegDst,RegWrite,Branch,ALUSrc,MemRead,MemWrite,MemtoReg,busy,illegal,count}
  wire [13:0] act = {o_ce, o_regdst, o_regwrite, o_branch, o_alusrc, o_memread,
                     o_memwrite, o_memtoreg, o_busy, o_illegal, o_cnt};

  task automatic check(input string name, input logic [13:0] a, input logic [13:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s @%0t: got %b want %b", name, $time, a, e);
    end
  endtask

  always @(negedge clk) if (q.size() > 0) check("cycle", act, q.pop_front());

  task automatic step(input logic c, input logic [5:0] o, input logic [7:0] ctrl, input logic busy);
    @(posedge clk);
    #1;
    ce = c;
    opcode = o;
    q.push_back({ctrl, busy, ill_exp, cnt_exp});
  endtask

  task automatic instr(input logic [5:0] o, input logic c);
    logic [7:0] seq [5];
    int n;
    case (o)
      OP_LW:    begin seq = '{8'h80, 8'h00, 8'h09, 8'h0D, 8'h29}; n = 5; end
      OP_RTYPE: begin seq = '{8'h80, 8'h00, 8'h40, 8'h60, 8'h00}; n = 4; end
      OP_SW:    begin seq = '{8'h80, 8'h00, 8'h08, 8'h0A, 8'h00}; n = 4; end
      OP_BEQ:   begin seq = '{8'h80, 8'h00, 8'h10, 8'h00, 8'h00}; n = 3; end
      OP_ADDI:  begin seq = '{8'h80, 8'h00, 8'h08, 8'h28, 8'h00}; n = 4; end
      default:  begin seq = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00}; n = 2; end
    endcase
    for (int i = 0; i < n; i++) step(c, i == 1 ? o : 6'h3f, seq[i], 1'b1);
    if (n == 2) ill_exp = 1'b1;
    else cnt_exp++;
  endtask

  initial begin
    #1 check("reset_init", act, 14'b0);
    #11 rst_n = 1;
    step(0, 6'h3f, 8'h00, 0);
    step(0, 6'h3f, 8'h00, 0);
    step(1, 6'h3f, 8'h00, 0);
    instr(OP_LW, 1);
    instr(OP_RTYPE, 1);
    instr(OP_SW, 1);
    instr(OP_BEQ, 1);
    instr(6'h3f, 1);
    instr(OP_ADDI, 0);
    step(0, 6'h3f, 8'h00, 0);
    step(0, 6'h3f, 8'h00, 0);
    // lw aborted by reset while in MEM
    step(1, 6'h3f, 8'h00, 0);
    step(1, 6'h3f, 8'h80, 1);
    step(1, OP_LW, 8'h00, 1);
    step(1, 6'h3f, 8'h09, 1);
    step(1, 6'h3f, 8'h0D, 1);
    @(negedge clk);
    #1 rst_n = 0;
    ce = 0;
    #1 cnt_exp = 0;
    ill_exp = 0;
    check("async_reset", act, 14'b0);
    @(negedge clk);
    #2 rst_n = 1;
    step(0, 6'h3f, 8'h00, 0);
    step(0, 6'h3f, 8'h00, 0);
    step(1, 6'h3f, 8'h00, 0);
    for (int k = 0; k < 16; k++) instr(OP_ADDI, k < 15);
    step(0, 6'h3f, 8'h00, 0);
    step(0, 6'h3f, 8'h00, 0);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multi-cycle main control unit for the MIPS datapath. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB. It samples the opcode that the datapath returns from decode, and drives the datapath's control inputs: clock enable, RegDst, RegWrite, Branch, ALUSrc, MemRead, MemWrite and MemtoReg. Until now a bench drove these inputs by hand. It instantiates directly beside `datapath`, with outputs wired to the matching `d_i_*` inputs and `cu_i_opcode` fed from `ds_es_o_opcode`.

## Interface
- CNT_WIDTH, 16, width of retired-instruction counter
- cu_clk  in  1  clock; all state changes on rising edge
- cu_rst  in  1  asynchronous, active-low reset
- cu_i_ce  in  1  run enable; sampled on entry to FETCH
- cu_i_opcode  in  `OPCODE_WIDTH (6)  opcode from the datapath decode stage
- cu_o_ce  out  1  datapath clock enable; PC/IMEM advance
- cu_o_RegDst  out  1  1 = write rt field is rd (R-type)
- cu_o_RegWrite  out  1  register file write strobe
- cu_o_Branch  out  1  branch compare/select strobe
- cu_o_ALUSrc  out  1  1 = ALU operand B is the immediate
- cu_o_MemRead  out  1  data memory read strobe
- cu_o_MemWrite  out  1  data memory write strobe
- cu_o_MemtoReg  out  1  1 = write-back data comes from memory
- cu_o_busy  out  1  state != IDLE
- cu_o_illegal  out  1  sticky flag: an unsupported opcode was decoded
- cu_o_instr_count  out  CNT_WIDTH  retired legal instructions, wraps

## Operation
- Supported opcodes:
  - R-type 6'b000000
  - lw 6'b100011
  - sw 6'b101011
  - beq 6'b000100
  - addi 6'b001000
  - Anything else is illegal.
- States and transitions:
  - IDLE → FETCH when cu_i_ce=1.
  - FETCH → DECODE, always.
  - DECODE: the opcode is latched into the internal op register. Illegal opcode: set cu_o_illegal and go to the completion branch. Otherwise go to EXEC.
  - EXEC: R-type/addi → WB; lw/sw → MEM; beq → complete.
  - MEM: lw → WB; sw → complete.
  - WB → complete.
  - Complete: go to FETCH if cu_i_ce=1, else IDLE. cu_o_instr_count += 1 for legal instructions only.
- Outputs are Moore, decoded from the state register and the latched op register only. There is no combinational path from cu_i_opcode or cu_i_ce to any output.
- cu_o_ce=1 only in FETCH.
- RegDst, ALUSrc and MemtoReg are level signals, held from EXEC through the last state of the instruction and 0 elsewhere:
  - RegDst=1 for R-type.
  - ALUSrc=1 for lw/sw/addi.
  - MemtoReg=1 for lw.
- Single-state strobes:
  - Branch=1 in EXEC for beq.
  - MemRead=1 in MEM for lw.
  - MemWrite=1 in MEM for sw.
  - RegWrite=1 in WB only.
- cu_o_illegal clears only on reset.
- cu_o_instr_count wraps from 2^CNT_WIDTH-1 to 0.

## Timing
- Reset (async assert, any state): state=IDLE, op register=0, every output 0, counter=0, illegal=0. Release is synchronous to the next cu_clk edge.
- Reset mid-instruction aborts it: no strobe completes, and the counter is not incremented.
- Cycles per instruction, FETCH to last state inclusive:
  - R-type/addi: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - illegal: 2
- Counter increments on the clock edge leaving the last state.
- cu_i_opcode must be valid in the DECODE cycle, i.e. the cycle after cu_o_ce is high. It is ignored in all other states.
- If cu_i_ce drops mid-instruction, the instruction completes, then the block goes to IDLE.
- Back-to-back: with cu_i_ce=1, the next FETCH immediately follows the last state, with no bubble.

## Structure
- The shared define header gains:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI)
  - state encodings (3-bit, IDLE=0)
- It reuses the existing `OPCODE_WIDTH` define.
- One sub-module, `main_decoder`: combinational opcode → {is_r, is_lw, is_sw, is_beq, is_addi, illegal}. Instantiated once, on the latched op register.
- Top level: state register, op register, next-state logic, output decode, counter.

## Test plan
- Reset, then cu_i_ce=1, opcode 100011 (lw):
  - cu_o_ce high for 1 cycle.
  - ALUSrc=MemtoReg=1 for 3 cycles.
  - MemRead in cycle 4, RegWrite in cycle 5.
  - Count becomes 1; next FETCH in cycle 6.
- R-type 000000 then sw 101011, back-to-back:
  - R-type: RegDst=1 in EXEC/WB; RegWrite only in cycle 4.
  - sw: MemWrite only in cycle 8; RegWrite never asserted.
  - Count=2.
- beq 000100: Branch=1 for exactly 1 cycle (cycle 3). No Mem*/RegWrite. Count +1.
- Opcode 111111:
  - 2-cycle sequence; cu_o_illegal=1 and stays 1.
  - Count unchanged; the following addi 001000 executes normally.
- Assert cu_rst=0 during MEM of lw: all outputs 0 immediately (asynchronously), count=0. After release, IDLE until cu_i_ce=1.
- CNT_WIDTH=4, 16 addi instructions: count wraps 15→0. cu_i_ce=0 during the 16th: cu_o_busy=0 after it completes.
